// File: rtl/cla_seq_adder_pkg.sv
// cla_defs: shared definitions for the sequential carry-lookahead adder.
//   state_t        FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   DEF_WIDTH      default operand width
//   DEF_SLICE      default bits processed per cycle
//   clog2()        ceiling log2 for elaboration-time sizing
package cla_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned DEF_SLICE = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cla_seq_adder_slice.sv
// cla_slice: one SLICE-bit carry-lookahead adder built from 4-bit CLA groups
// and a lookahead carry unit across the groups.
//   i_a, i_b  SLICE-bit addends
//   i_cin     carry into bit 0
//   o_sum     SLICE-bit sum
//   o_cout    carry out of the top bit
//   o_p, o_g  slice-level propagate / generate
module cla_slice
  import cla_defs::*;
#(
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout,
  output logic             o_p,
  output logic             o_g
);

  localparam int unsigned NG = SLICE / 4;

  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_c;
  logic [NG-1:0]    w_gp;
  logic [NG-1:0]    w_gg;
  logic [NG:0]      w_gc;
  logic             w_sg;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Group propagate/generate of each 4-bit CLA group.
  always_comb begin
    w_gp = '0;
    w_gg = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  // Lookahead carry unit: group carry-ins and slice-level P/G.
  always_comb begin
    w_gc    = '0;
    w_gc[0] = i_cin;
    w_sg    = 1'b0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
      w_sg      = w_gg[k] | (w_gp[k] & w_sg);
    end
  end

  // Bit carries inside each group, expanded from the group carry-in.
  always_comb begin
    w_c = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[NG];
  assign o_p    = &w_gp;
  assign o_g    = w_sg;

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle adder/subtractor. Processes WIDTH-bit operands
// one SLICE-bit chunk per clock through a single shared cla_slice.
//   clk, rst  clock; asynchronous active-high reset
//   start     request, accepted in IDLE or DONE
//   sub       0: a+b+c_in, 1: a-b
//   a, b      operands, c_in carry-in (add mode), sampled with start
//   busy      high while slices are being processed
//   done      one-cycle pulse when s/c_out/ovf are valid
//   s         result register
//   c_out     carry-out (add) / not-borrow (sub)
//   ovf       two's-complement overflow of the result
module cla_seq_adder
  import cla_defs::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NS = WIDTH / SLICE;
  localparam int unsigned IW = (clog2(NS) > 0) ? clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be an integer multiple of SLICE");
  end
  if ((SLICE % 4) != 0 || SLICE == 0) begin : g_bad_slice
    $error("cla_seq_adder: SLICE must be a non-zero multiple of 4");
  end

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_cr;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [SLICE-1:0] w_a_sl;
  logic [SLICE-1:0] w_b_sl;
  logic [SLICE-1:0] w_sum;
  logic             w_cout;
  logic             w_p;
  logic             w_g;
  logic             w_next_cr;
  logic             w_accept;
  logic [WIDTH-1:0] w_opb;

  assign w_a_sl = r_opa[r_idx*SLICE +: SLICE];
  assign w_b_sl = r_opb[r_idx*SLICE +: SLICE];

  cla_slice #(.SLICE(SLICE)) u_slice (
    .i_a   (w_a_sl),
    .i_b   (w_b_sl),
    .i_cin (r_cr),
    .o_sum (w_sum),
    .o_cout(w_cout),
    .o_p   (w_p),
    .o_g   (w_g)
  );

  // Inter-slice carry formed from the slice P/G; identical to w_cout but keeps
  // the register input one lookahead term away from r_cr.
  assign w_next_cr = w_g | (w_p & r_cr);

  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_opb    = sub ? ~b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cr     <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_s      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_s[r_idx*SLICE +: SLICE] <= w_sum;
          r_cr <= w_next_cr;
          if (r_idx == LAST) begin
            r_cout  <= w_cout;
            r_ovf   <= (r_sign_a == r_sign_b) && (w_sum[SLICE-1] != r_sign_a);
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            r_opa    <= a;
            r_opb    <= w_opb;
            r_cr     <= sub ? 1'b1 : c_in;
            r_sign_a <= a[WIDTH-1];
            r_sign_b <= w_opb[WIDTH-1];
            r_idx    <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign s     = r_s;
  assign c_out = r_cout;
  assign ovf   = r_ovf;

endmodule
